// File: rtl/c2h_credit_mgr_pkg.sv
// Shared constants, state encoding and packet-credit helper for the C2H credit manager.
package c2h_credit_pkg;

   localparam int TM_DSC_BITS  = 16;
   localparam int QID_WIDTH    = 11;
   localparam int CREDIT_BYTES = 4096;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } c2h_state_e;

   // Descriptors consumed by one packet: ceil(bytes / CREDIT_BYTES), never below 1.
   function automatic logic [15:0] pkt_credits(input logic [15:0] bytes);
      if (bytes < 16'(CREDIT_BYTES)) begin
         return 16'd1;
      end
      return {12'd0, bytes[15:12]} + {15'd0, |bytes[11:0]};
   endfunction

endpackage

// File: rtl/c2h_credit_mgr_if.sv
// QDMA descriptor-status channel: master drives the status fields, slave returns rdy.
interface c2h_credit_mgr_if #(
   parameter int QID_W = c2h_credit_pkg::QID_WIDTH
);

   logic             vld;
   logic             qen;
   logic             byp;
   logic             dir;
   logic             mm;
   logic             qinv;
   logic             irq_arm;
   logic [QID_W-1:0] qid;
   logic [15:0]      avl;
   logic             rdy;

   modport master (
      output vld, qen, byp, dir, mm, qinv, irq_arm, qid, avl,
      input  rdy
   );

   modport slave (
      input  vld, qen, byp, dir, mm, qinv, irq_arm, qid, avl,
      output rdy
   );

endinterface

// File: rtl/c2h_credit_mgr_mul.sv
// Bit-serial shift-add multiplier: one multiplier bit per cycle, BW cycles per product,
// result saturated to AW bits.
module credit_mul #(
   parameter int AW = 16,
   parameter int BW = 16
) (
   input  logic          axi_aclk,
   input  logic          user_resetn,
   input  logic          start_i,
   input  logic          clr_i,
   input  logic [AW-1:0] a_i,
   input  logic [BW-1:0] b_i,
   output logic          done_o,
   output logic [AW-1:0] prod_o
);

   localparam int PW = AW + BW;
   localparam int CW = $clog2(BW + 1);

   logic [PW-1:0] mcand_q, mcand_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [BW-1:0] mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      if (clr_i) begin
         mcand_d  = '0;
         acc_d    = '0;
         mplier_d = '0;
         cnt_d    = '0;
      end else if (start_i) begin
         mcand_d  = PW'(a_i);
         acc_d    = '0;
         mplier_d = b_i;
         cnt_d    = CW'(BW);
      end else if (cnt_q != '0) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         done_d   = (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge axi_aclk or negedge user_resetn) begin
      if (!user_resetn) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   // Full-width accumulator cannot wrap, so any upper bit set means the result overflowed.
   assign done_o = done_q;
   assign prod_o = (|acc_q[PW-1:AW]) ? '1 : acc_q[AW-1:0];

endmodule

// File: rtl/c2h_credit_mgr.sv
// C2H credit manager: sizes a run in descriptors, then forwards descriptor-status credits
// for the generator's queue as single-cycle credit_updt pulses until the run is covered.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a rising edge of control_reg[1]
// CALC    | serial multiply perpkt * num_pkt in progress
// RUN     | accepting matching statuses, pulsing pending credits
// DONE    | run covered; flush last pending credits, wait for enable drop
module c2h_credit_mgr #(
   parameter int TM_DSC_BITS = c2h_credit_pkg::TM_DSC_BITS,
   parameter int QID_WIDTH   = c2h_credit_pkg::QID_WIDTH
) (
   input  logic                   axi_aclk,
   input  logic                   user_resetn,
   input  logic [31:0]            control_reg,
   input  logic [QID_WIDTH-1:0]   c2h_qid,
   input  logic [15:0]            txr_size,
   input  logic [15:0]            num_pkt,
   input  logic                   c2h_end,
   c2h_credit_mgr_if.slave        tm_dsc_sts,
   output logic [TM_DSC_BITS-1:0] credit_in,
   output logic [TM_DSC_BITS-1:0] credit_perpkt_in,
   output logic [TM_DSC_BITS-1:0] credit_needed,
   output logic                   credit_updt
);

   import c2h_credit_pkg::*;

   c2h_state_e             state_q, state_d;
   logic                   en_prev_q;
   logic                   rdy_q;
   logic                   updt_q, updt_d;
   logic [TM_DSC_BITS-1:0] pend_q, pend_d;
   logic [TM_DSC_BITS-1:0] grant_q, grant_d;
   logic [TM_DSC_BITS-1:0] cin_q, cin_d;
   logic [TM_DSC_BITS-1:0] perpkt_lat_q, perpkt_lat_d;
   logic [TM_DSC_BITS-1:0] perpkt_q, perpkt_d;
   logic [TM_DSC_BITS-1:0] needed_q, needed_d;

   logic                   run_en, start_rise, abort;
   logic                   sts_hit, qinv_hit, avl_hit;
   logic [TM_DSC_BITS-1:0] perpkt_new, avl_add, pend_sum, grant_sum;
   logic [TM_DSC_BITS:0]   pend_wide, grant_wide;
   logic                   mul_start, mul_clr, mul_done;
   logic [TM_DSC_BITS-1:0] mul_prod;
   logic                   unused_ok;

   assign run_en     = control_reg[1];
   assign start_rise = run_en & ~en_prev_q;
   assign abort      = (state_q != ST_IDLE) & (~run_en | c2h_end);

   assign sts_hit  = tm_dsc_sts.vld & rdy_q & tm_dsc_sts.qen & tm_dsc_sts.dir
                   & ~tm_dsc_sts.mm & (tm_dsc_sts.qid == c2h_qid);
   assign qinv_hit = sts_hit & tm_dsc_sts.qinv;
   assign avl_hit  = sts_hit & ~tm_dsc_sts.qinv & (state_q == ST_RUN);

   assign perpkt_new = TM_DSC_BITS'(pkt_credits(txr_size));
   assign avl_add    = avl_hit ? TM_DSC_BITS'(tm_dsc_sts.avl) : '0;

   assign pend_wide  = {1'b0, pend_q} + {1'b0, avl_add};
   assign grant_wide = {1'b0, grant_q} + {1'b0, avl_add};
   assign pend_sum   = pend_wide[TM_DSC_BITS] ? '1 : pend_wide[TM_DSC_BITS-1:0];
   assign grant_sum  = grant_wide[TM_DSC_BITS] ? '1 : grant_wide[TM_DSC_BITS-1:0];

   credit_mul #(
      .AW (TM_DSC_BITS),
      .BW (16)
   ) u_mul (
      .axi_aclk    (axi_aclk),
      .user_resetn (user_resetn),
      .start_i     (mul_start),
      .clr_i       (mul_clr),
      .a_i         (perpkt_new),
      .b_i         (num_pkt),
      .done_o      (mul_done),
      .prod_o      (mul_prod)
   );

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      grant_d      = grant_q;
      updt_d       = 1'b0;
      cin_d        = cin_q;
      perpkt_lat_d = perpkt_lat_q;
      perpkt_d     = perpkt_q;
      needed_d     = needed_q;
      mul_start    = 1'b0;
      mul_clr      = 1'b0;

      if (qinv_hit || abort) begin
         state_d = ST_IDLE;
         pend_d  = '0;
         grant_d = '0;
         mul_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_rise) begin
                  state_d      = ST_CALC;
                  perpkt_lat_d = perpkt_new;
                  mul_start    = 1'b1;
               end
            end
            ST_CALC: begin
               if (mul_done) begin
                  state_d  = ST_RUN;
                  perpkt_d = perpkt_lat_q;
                  needed_d = mul_prod;
               end
            end
            ST_RUN, ST_DONE: begin
               if (avl_hit) begin
                  grant_d = grant_sum;
                  if (grant_sum >= needed_q) begin
                     state_d = ST_DONE;
                  end
               end
               // The arrival is folded in before the pulse decision, so a status
               // that lands in a pulse cycle waits in pending for the next one.
               if ((pend_sum != '0) && !updt_q) begin
                  updt_d = 1'b1;
                  cin_d  = pend_sum;
                  pend_d = '0;
               end else begin
                  pend_d = pend_sum;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_aclk or negedge user_resetn) begin
      if (!user_resetn) begin
         state_q      <= ST_IDLE;
         en_prev_q    <= 1'b1;
         rdy_q        <= 1'b0;
         updt_q       <= 1'b0;
         pend_q       <= '0;
         grant_q      <= '0;
         cin_q        <= '0;
         perpkt_lat_q <= '0;
         perpkt_q     <= '0;
         needed_q     <= '0;
      end else begin
         state_q      <= state_d;
         en_prev_q    <= run_en;
         rdy_q        <= 1'b1;
         updt_q       <= updt_d;
         pend_q       <= pend_d;
         grant_q      <= grant_d;
         cin_q        <= cin_d;
         perpkt_lat_q <= perpkt_lat_d;
         perpkt_q     <= perpkt_d;
         needed_q     <= needed_d;
      end
   end

   // en_prev_q resets high so an enable held through reset is not seen as a new start.
   assign tm_dsc_sts.rdy   = rdy_q;
   assign credit_in        = cin_q;
   assign credit_perpkt_in = perpkt_q;
   assign credit_needed    = needed_q;
   assign credit_updt      = updt_q;

   assign unused_ok = ^{control_reg[31:2], control_reg[0], tm_dsc_sts.byp, tm_dsc_sts.irq_arm};

endmodule

// File: doc/c2h_credit_mgr.md
C2H_CREDIT_MGR -- requirements
Module: c2h_credit_mgr

Interface
REQ-001 Parameter TM_DSC_BITS, 16, width of all credit quantities.
REQ-002 Parameter QID_WIDTH, 11, queue id width.
REQ-003 axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-004 user_resetn  in  1  reset, asynchronous, active-low.
REQ-005 control_reg  in  32  bit 1 = C2H run enable; other bits ignored.
REQ-006 c2h_qid  in  QID_WIDTH  queue owned by the generator.
REQ-007 txr_size  in  16  packet length in bytes.
REQ-008 num_pkt  in  16  packets per run.
REQ-009 tm_dsc_sts_vld / _qen / _byp / _dir / _mm / _qinv / _irq_arm  in  1 each  QDMA descriptor-status fields.
REQ-010 tm_dsc_sts_qid  in  QID_WIDTH; tm_dsc_sts_avl  in  16  newly available descriptors.
REQ-011 tm_dsc_sts_rdy  out  1  status accept.
REQ-012 c2h_end  in  1  generator run-complete pulse.
REQ-013 credit_in, credit_perpkt_in, credit_needed  out  TM_DSC_BITS each; credit_updt  out  1.

Function
REQ-014 A status SHALL be accepted when vld & rdy & qen & dir=1 & mm=0 & qid=c2h_qid; byp and irq_arm are ignored.
REQ-015 tm_dsc_sts_rdy SHALL be 0 in reset and 1 in every other cycle; non-matching statuses are consumed and discarded.
REQ-016 States: IDLE, CALC, RUN, DONE.
REQ-017 IDLE->CALC on a rising edge of control_reg[1]; txr_size and num_pkt are latched in that cycle.
REQ-018 perpkt = 1 if latched txr_size < 4096, else txr_size[15:12] + |txr_size[11:0]; txr_size=0 gives 1.
REQ-019 CALC runs a sequential shift-add multiply perpkt*num_pkt for exactly 16 cycles, saturating to 16'hFFFF, then enters RUN.
REQ-020 credit_perpkt_in and credit_needed SHALL update on RUN entry and hold until the next CALC.
REQ-021 In RUN, each accepted avl is added to a saturating pending register, and the same avl is added to a saturating granted_total register.
REQ-022 In RUN, if pending != 0 and credit_updt was 0 in the previous cycle, the block SHALL drive credit_updt=1 for one cycle with credit_in=pending, and clear pending.
REQ-023 An arrival in the pulse cycle SHALL land in pending after the clear, so it is never lost; pulses are therefore separated by at least one idle cycle.
REQ-024 Latency: an isolated accepted status in cycle N produces credit_updt in cycle N+1 with credit_in = avl.
REQ-025 RUN->DONE when granted_total >= credit_needed after the add; the pending value still flushes with one final pulse in DONE.
REQ-026 DONE ignores further statuses and returns to IDLE when control_reg[1]=0.
REQ-027 In CALC, RUN or DONE, control_reg[1]=0 or c2h_end=1 SHALL force IDLE next cycle; pending and granted_total are cleared, and no pulse is issued.
REQ-028 An accepted qinv (matching qid) in any state SHALL clear pending and granted_total and force IDLE; its avl is not counted.
REQ-029 credit_in SHALL hold its last value when credit_updt=0.
REQ-030 Statuses arriving in IDLE or CALC SHALL be discarded.

Reset
REQ-031 On user_resetn=0, state=IDLE, and all outputs, pending, granted_total and the multiplier are 0, asynchronously.
REQ-032 Reset mid-CALC or mid-RUN SHALL abort with no pulse; after release, a fresh rising edge of control_reg[1] is required to start.

Structure
REQ-033 Package c2h_credit_pkg SHALL hold TM_DSC_BITS, QID_WIDTH, CREDIT_BYTES=4096 and the state enum.
REQ-034 The multiplier SHALL be the sub-module credit_mul (start/done, 16-cycle, saturating).

Verification
REQ-035 txr_size=4096, num_pkt=32, control_reg 0->2 -> RUN after 17 cycles; credit_perpkt_in=1, credit_needed=32.
REQ-036 txr_size=4097 -> perpkt 2; txr_size=100 -> perpkt 1; txr_size=16'hF000 with num_pkt=16'hFFFF -> credit_needed=16'hFFFF.
REQ-037 Matching status avl=32 in cycle N -> credit_updt in cycle N+1 with credit_in=32 -> DONE; the same status with wrong qid, dir=0 or mm=1 -> no pulse.
REQ-038 avl=5 in cycles N, N+1, N+2 -> pulses at N+1 (credit_in=5) and N+3 (credit_in=10); no pulse at N+2.
REQ-039 qinv mid-RUN with pending=7 -> no pulse, IDLE next cycle; control_reg=2 again -> CALC restarts cleanly.
REQ-040 user_resetn=0 mid-CALC -> all outputs 0 immediately; release without a control_reg[1] edge -> stays IDLE.
